uart_tx_r1: RTL and testbench
=============================

# uart_tx_r1

Parametrised UART transmitter, successor to the single-rate serialiser. Accepts one data word per valid/ready handshake and serialises it as start bit, data bits, optional parity bit and one or two stop bits. Each bit is held for a programmable number of clock cycles, so one block serves any baud rate derived from the system clock. It sits between a byte source (FIFO or register interface) and the pad, and supports gap-free back-to-back frames.

## Interface

- DATA_BITS, 8, data word width; legal 5..9
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal ≥1
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, number of stop bits; legal 1 or 2
- START_BIT, 0, start-bit level; idle, stop and line-idle level is ~START_BIT
- LSB_FIRST, 1, 1 = data bit 0 sent first; 0 = MSB first

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- data_in  in  DATA_BITS  word to send; sampled only on accept
- valid  in  1  source has a word
- ready  out  1  block can accept a word this cycle
- busy  out  1  frame in progress
- tx_out  out  1  serial line, registered

## Operation

- Accept: a transfer occurs on a rising edge where valid && ready. data_in is latched into the shift register, and the parity bit is computed from it at accept time.
- Parity bit:
  - Odd: the parity bit makes the count of ones in data plus parity odd (~^data).
  - Even: the parity bit makes that count even (^data).
- States:
  - IDLE: tx_out = ~START_BIT, ready = 1. On accept → START.
  - START: tx_out = START_BIT for CLKS_PER_BIT cycles → DATA.
  - DATA: DATA_BITS bits, each for CLKS_PER_BIT cycles, in the order set by LSB_FIRST. After the last bit → PARITY if PARITY != 0, else → STOP.
  - PARITY: parity bit for CLKS_PER_BIT cycles → STOP.
  - STOP: tx_out = ~START_BIT for STOP_BITS*CLKS_PER_BIT cycles. In its last cycle: accept → START, else → IDLE.
- Counters:
  - Baud counter is 0..CLKS_PER_BIT-1, width max(1, $clog2(CLKS_PER_BIT)). It wraps to 0 at each bit boundary.
  - Bit counter width is $clog2(DATA_BITS+2) and counts data bits and stop bits.
  - All comparisons use the counter width, not 32-bit integers.
- ready is asserted in IDLE, and in the final cycle of the final stop bit. It is deasserted everywhere else.
- valid while ready = 0 is ignored. No data is captured and no error is raised. The source must hold valid until it is accepted.
- busy = (state != IDLE).
- Frame length F = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.

## Timing

- Reset values, in the cycle after rst is sampled high:
  - state = IDLE, tx_out = ~START_BIT, ready = 1, busy = 0, counters = 0.
- Reset mid-frame aborts the frame. tx_out returns to ~START_BIT on the next edge and no partial stop bit is sent.
- Latency: if a word is accepted at edge k, tx_out shows the start bit from edge k+1 through edge k+CLKS_PER_BIT.
- Bit n (0 = start) occupies edges k+1+n*CLKS_PER_BIT through k+(n+1)*CLKS_PER_BIT.
- Back-to-back:
  - An accept in the last stop cycle (edge k+F) makes the next start bit begin at k+F+1, with zero idle cycles.
  - If valid arrives later, at least one idle cycle separates frames.
- busy rises at k+1 and falls at k+F+1 if no back-to-back accept occurs.
- CLKS_PER_BIT = 1: every state lasts exactly one cycle per bit, and ready is high for only one cycle of STOP.
- The rst and valid inputs are sampled on the same edge; rst wins and no accept occurs.

## Test plan

- Basic frame. Config: DATA_BITS=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1. Send 0xA5.
  - tx_out must be 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, for 40 cycles total.
  - busy is high for exactly 40 cycles; ready is low from k+1 to k+39.
- Parity. Send 0xA5 (four ones).
  - PARITY=2: parity bit 0.
  - PARITY=1: parity bit 1.
  - Send 0x07 with PARITY=2: parity bit 1.
  - In all cases the frame is 44 cycles.
- Back-to-back streaming. Hold valid high with 0x00 and then 0xFF, CLKS_PER_BIT=4.
  - The second start bit begins at cycle 41 with no idle gap.
  - Exactly two accepts occur.
- Ignored valid. Pulse valid with 0x3C during the DATA bits of a 0xA5 frame.
  - The frame is unchanged and no second frame is sent.
- Reset mid-frame. Assert rst during data bit 3.
  - Next cycle: tx_out = 1, busy = 0, ready = 1.
  - A fresh 0x5A frame sent afterwards is correct.
- Corner configuration. DATA_BITS=7, CLKS_PER_BIT=1, STOP_BITS=2, LSB_FIRST=0. Send 0x41.
  - tx_out must be 0,1,0,0,0,0,0,1,1,1, a frame of 10 cycles.

Source files
------------

// File: rtl/uart_tx_r1.sv
// UART transmitter: one word per valid/ready accept, serialised as start, data,
// optional parity and one or two stop bits, each bit held CLKS_PER_BIT cycles.
module uart_tx_r1 #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter bit          START_BIT    = 1'b0,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx_out
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(DATA_BITS + 2);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_MAX = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_MAX = CW'(STOP_BITS - 1);
  localparam logic          IDLE_LVL = ~START_BIT;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_n;
  logic [BW-1:0]          baud_q, baud_n;
  logic [CW-1:0]          bit_q, bit_n;
  logic [DATA_BITS-1:0]   shreg_q, shreg_n;
  logic                   par_q, par_n;
  logic                   tx_n, ready_n, busy_n;
  logic                   accept, baud_last;

  assign accept    = valid && ready;
  assign baud_last = (baud_q == BAUD_MAX);

  // State, counters, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_out  <= IDLE_LVL;
      ready   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      par_q   <= par_n;
      tx_out  <= tx_n;
      ready   <= ready_n;
      busy    <= busy_n;
    end
  end

  // Next state, counters and shift register
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    par_n   = par_q;
    if (state_q != S_IDLE) begin
      baud_n = baud_last ? '0 : baud_q + BW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_n = S_START;
          baud_n  = '0;
          bit_n   = '0;
          shreg_n = data_in;
          par_n   = (PARITY == 1) ? ~^data_in : ^data_in;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shreg_n = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          if (bit_q == DATA_MAX) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_q + CW'(1);
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (bit_q == STOP_MAX) begin
            bit_n = '0;
            if (accept) begin
              state_n = S_START;
              shreg_n = data_in;
              par_n   = (PARITY == 1) ? ~^data_in : ^data_in;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_q + CW'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Output values for the cycle after the edge, taken from the next state
  always_comb begin
    tx_n    = IDLE_LVL;
    ready_n = 1'b0;
    busy_n  = (state_n != S_IDLE);
    case (state_n)
      S_IDLE:   ready_n = 1'b1;
      S_START:  tx_n = START_BIT;
      S_DATA:   tx_n = LSB_FIRST ? shreg_n[0] : shreg_n[DATA_BITS-1];
      S_PARITY: tx_n = par_n;
      S_STOP:   ready_n = (bit_n == STOP_MAX) && (baud_n == BAUD_MAX);
      default:  tx_n = IDLE_LVL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_r1.sv
// Directed bench for uart_tx_r1 across four parameter sets; outputs are
// sampled 1 time unit after each rising edge.
module tb_uart_tx_r1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] v = 4'b0;
  logic [3:0] tx, rdy, bsy;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [6:0] d3 = '0;
  int checks = 0;
  int errors = 0;
  int acc0 = 0;

  always #5 clk = ~clk;

  uart_tx_r1 #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1),
               .START_BIT(1'b0), .LSB_FIRST(1'b1))
    u_plain (.clk(clk), .rst(rst), .data_in(d0), .valid(v[0]),
             .ready(rdy[0]), .busy(bsy[0]), .tx_out(tx[0]));

  uart_tx_r1 #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1),
               .START_BIT(1'b0), .LSB_FIRST(1'b1))
    u_even (.clk(clk), .rst(rst), .data_in(d1), .valid(v[1]),
            .ready(rdy[1]), .busy(bsy[1]), .tx_out(tx[1]));

  uart_tx_r1 #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1),
               .START_BIT(1'b0), .LSB_FIRST(1'b1))
    u_odd (.clk(clk), .rst(rst), .data_in(d2), .valid(v[2]),
           .ready(rdy[2]), .busy(bsy[2]), .tx_out(tx[2]));

  uart_tx_r1 #(.DATA_BITS(7), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2),
               .START_BIT(1'b0), .LSB_FIRST(1'b0))
    u_corner (.clk(clk), .rst(rst), .data_in(d3), .valid(v[3]),
              .ready(rdy[3]), .busy(bsy[3]), .tx_out(tx[3]));

  always @(posedge clk) if (!rst && v[0] && rdy[0]) acc0 <= acc0 + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int sel, input logic [7:0] data);
    case (sel)
      0: d0 = data;
      1: d1 = data;
      2: d2 = data;
      default: d3 = data[6:0];
    endcase
  endtask

  task automatic check_idle(input int sel, input string name);
    checks++;
    if (tx[sel] !== 1'b1) begin
      errors++; $display("FAIL %s idle tx got %b want 1", name, tx[sel]);
    end
    checks++;
    if (bsy[sel] !== 1'b0) begin
      errors++; $display("FAIL %s idle busy got %b want 0", name, bsy[sel]);
    end
    checks++;
    if (rdy[sel] !== 1'b1) begin
      errors++; $display("FAIL %s idle ready got %b want 1", name, rdy[sel]);
    end
  endtask

  // Sends one frame and checks tx, busy and ready on every cycle; exp[0] is the start bit.
  // pulse_at >= 0 pulses valid (0x3C) on instance 0 at that sample.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic [0:15] exp,
                            input int nbits, input int cpb, input int pulse_at,
                            input string name);
    int f;
    int a0;
    logic er;
    f  = nbits * cpb;
    a0 = acc0;
    load(sel, data);
    v[sel] = 1'b1;
    step;
    v[sel] = 1'b0;
    for (int i = 0; i < f; i++) begin
      if (i == pulse_at) begin
        d0 = 8'h3C; v[0] = 1'b1;
      end else if (i == pulse_at + 1) begin
        v[0] = 1'b0;
      end
      er = (i == f - 1);
      checks++;
      if (tx[sel] !== exp[i / cpb]) begin
        errors++;
        $display("FAIL %s tx cycle %0d got %b want %b", name, i, tx[sel], exp[i / cpb]);
      end
      checks++;
      if (bsy[sel] !== 1'b1) begin
        errors++; $display("FAIL %s busy cycle %0d got %b want 1", name, i, bsy[sel]);
      end
      checks++;
      if (rdy[sel] !== er) begin
        errors++; $display("FAIL %s ready cycle %0d got %b want %b", name, i, rdy[sel], er);
      end
      step;
    end
    check_idle(sel, name);
    if (sel == 0) begin
      checks++;
      if (acc0 - a0 !== 1) begin
        errors++; $display("FAIL %s accepts got %0d want 1", name, acc0 - a0);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    v[0] = 1'b1;
    d0 = 8'hFF;
    step;
    step;
    for (int s = 0; s < 4; s++) check_idle(s, "reset");
    v[0] = 1'b0;
    rst = 1'b0;
    step;
    check_idle(0, "reset_release");
  endtask

  task automatic test_basic;
    send_frame(0, 8'hA5, 16'b0101001011_000000, 10, 4, -1, "basic_a5");
  endtask

  task automatic test_parity;
    send_frame(1, 8'hA5, 16'b01010010101_00000, 11, 4, -1, "even_a5");
    send_frame(2, 8'hA5, 16'b01010010111_00000, 11, 4, -1, "odd_a5");
    send_frame(1, 8'h07, 16'b01110000011_00000, 11, 4, -1, "even_07");
  endtask

  task automatic test_back_to_back;
    logic [0:19] exp2;
    int a0;
    logic er;
    exp2 = 20'b0_00000000_1_0_11111111_1;
    a0 = acc0;
    d0 = 8'h00;
    v[0] = 1'b1;
    step;
    for (int i = 0; i < 80; i++) begin
      if (i == 0) d0 = 8'hFF;
      if (i == 40) v[0] = 1'b0;
      er = (i == 39) || (i == 79);
      checks++;
      if (tx[0] !== exp2[i / 4]) begin
        errors++; $display("FAIL b2b tx cycle %0d got %b want %b", i, tx[0], exp2[i / 4]);
      end
      checks++;
      if (bsy[0] !== 1'b1) begin
        errors++; $display("FAIL b2b busy cycle %0d got %b want 1", i, bsy[0]);
      end
      checks++;
      if (rdy[0] !== er) begin
        errors++; $display("FAIL b2b ready cycle %0d got %b want %b", i, rdy[0], er);
      end
      step;
    end
    check_idle(0, "b2b_end");
    checks++;
    if (acc0 - a0 !== 2) begin
      errors++; $display("FAIL b2b accepts got %0d want 2", acc0 - a0);
    end
  endtask

  task automatic test_ignored_valid;
    send_frame(0, 8'hA5, 16'b0101001011_000000, 10, 4, 10, "ignored_valid");
    for (int i = 0; i < 6; i++) begin
      step;
      check_idle(0, "ignored_after");
    end
  endtask

  task automatic test_reset_mid_frame;
    d0 = 8'hA5;
    v[0] = 1'b1;
    step;
    v[0] = 1'b0;
    for (int i = 0; i < 17; i++) step;
    rst = 1'b1;
    step;
    check_idle(0, "mid_reset");
    rst = 1'b0;
    step;
    send_frame(0, 8'h5A, 16'b0010110101_000000, 10, 4, -1, "after_reset_5a");
  endtask

  task automatic test_corner;
    send_frame(3, 8'h41, 16'b0100000111_000000, 10, 1, -1, "corner_41");
  endtask

  initial begin
    #1;
    test_reset;
    test_basic;
    test_parity;
    test_back_to_back;
    test_ignored_valid;
    test_reset_mid_frame;
    test_corner;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
